// File: rtl/spi_cfg_master.sv
// spi_cfg_master: burst-write sequencer driving the SPI slow-control block's sclk/serial_in/iclk pins.
// Define SPI_CFG_AUTO_IRST_EN to close every write frame with the 8-pulse iclk reset sequence.
module spi_cfg_master #(
  parameter int MAX_BYTES = 4,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          data_valid,
  input  logic [7:0]    data,
  output logic          data_ready,
  input  logic          rst_req,
  output logic          sclk,
  output logic          serial_in,
  output logic          iclk,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_DATA  = 3'd3,
    S_IRST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_phase, w_phase_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_sclk, w_sclk_nxt;
  logic       r_sin, w_sin_nxt;
  logic       r_iclk, w_iclk_nxt;
  logic [7:0] w_len_clamped;

  assign w_len_clamped = (32'(req_len) > 32'(MAX_BYTES)) ? 8'(MAX_BYTES) : 8'(req_len);

  // Handshake: a request transfers on req_valid && req_ready, a data byte on data_valid && data_ready.
  assign req_ready  = (r_state == S_IDLE);
  assign data_ready = (r_state == S_FETCH) && data_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign sclk       = r_sclk;
  assign serial_in  = r_sin;
  assign iclk       = r_iclk;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 8'd0;
      r_shift    <= 8'd0;
      r_sclk     <= 1'b0;
      r_sin      <= 1'b0;
      r_iclk     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sclk     <= w_sclk_nxt;
      r_sin      <= w_sin_nxt;
      r_iclk     <= w_iclk_nxt;
    end
  end

  // Pin values are computed for the next state so they leave the flops aligned with it.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_sclk_nxt     = 1'b0;
    w_sin_nxt      = r_sin;
    w_iclk_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sin_nxt     = 1'b0;
        w_phase_nxt   = 1'b0;
        w_bit_cnt_nxt = 3'd0;
        if (rst_req) begin
          w_state_nxt = S_IRST;
          w_iclk_nxt  = 1'b1;
        end else if (req_valid) begin
          w_state_nxt    = S_ADDR;
          w_shift_nxt    = req_addr;
          w_byte_cnt_nxt = w_len_clamped;
          w_sin_nxt      = req_addr[7];
        end
      end
      S_ADDR, S_DATA: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
          w_sclk_nxt  = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = 3'd0;
            if (r_byte_cnt != 8'd0) begin
              w_state_nxt = S_FETCH;
            end else begin
`ifdef SPI_CFG_AUTO_IRST_EN
              w_state_nxt = S_IRST;
              w_iclk_nxt  = 1'b1;
`else
              w_state_nxt = S_DONE;
`endif
              w_sin_nxt = 1'b0;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_sin_nxt     = r_shift[6];
          end
        end
      end
      S_FETCH: begin
        if (data_valid) begin
          w_state_nxt    = S_DATA;
          w_shift_nxt    = data;
          w_sin_nxt      = data[7];
          w_byte_cnt_nxt = (r_byte_cnt == 8'd0) ? 8'd0 : r_byte_cnt - 8'd1;
        end
      end
      S_IRST: begin
        w_sin_nxt = 1'b0;
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_DONE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_iclk_nxt    = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_sin_nxt   = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: bit stream, burst length, stall, clamp, rst_req priority, async reset.
module tb_spi_cfg_master;

  localparam int MAX_BYTES = 4;
  localparam int LW        = $clog2(MAX_BYTES + 1);
`ifdef SPI_CFG_AUTO_IRST_EN
  localparam int IRST_CYC    = 16;
  localparam int IRST_PULSES = 8;
`else
  localparam int IRST_CYC    = 0;
  localparam int IRST_PULSES = 0;
`endif

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_addr;
  logic [LW-1:0] req_len;
  logic          data_valid;
  logic [7:0]    data;
  logic          data_ready;
  logic          rst_req;
  logic          sclk;
  logic          serial_in;
  logic          iclk;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  spi_cfg_master #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .rst_req    (rst_req),
    .sclk       (sclk),
    .serial_in  (serial_in),
    .iclk       (iclk),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: samples on the falling edge, when all registered outputs are settled
  logic       bits_q[$];
  logic [7:0] exp_q[$];
  int  sclk_rises, iclk_pulses, dr_cnt, done_cnt, done_cyc;
  logic prev_sclk, prev_iclk, took;

  task automatic mon_clear();
    bits_q.delete();
    sclk_rises  = 0;
    iclk_pulses = 0;
    dr_cnt      = 0;
    done_cnt    = 0;
    done_cyc    = -1;
  endtask

  initial begin
    prev_sclk = 1'b0;
    prev_iclk = 1'b0;
    took      = 1'b0;
    mon_clear();
    forever begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        bits_q.push_back(serial_in);
        sclk_rises++;
      end
      if (iclk && !prev_iclk) iclk_pulses++;
      if (data_ready) begin
        dr_cnt++;
        took = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_sclk = sclk;
      prev_iclk = iclk;
    end
  end

  // data producer: offers prod_q in order, optional stall after byte stall_at is reached
  logic [7:0] prod_q[$];
  int prod_idx   = 0;
  int stall_at   = -1;
  int stall_len  = 0;
  int stall_left = 0;

  initial begin
    data_valid = 1'b0;
    data       = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (took) begin
        took = 1'b0;
        prod_idx++;
        if (prod_idx == stall_at) stall_left = stall_len;
      end
      if (stall_left > 0) begin
        data_valid = 1'b0;
        stall_left--;
      end else if (prod_idx < prod_q.size()) begin
        data_valid = 1'b1;
        data       = prod_q[prod_idx];
      end else begin
        data_valid = 1'b0;
      end
    end
  end

  task automatic prod_reset();
    prod_q.delete();
    prod_idx   = 0;
    stall_at   = -1;
    stall_len  = 0;
    stall_left = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done_cnt < n) chk("done_timeout", done_cnt, n);
  endtask

  task automatic check_stream(input string tag);
    int i;
    logic [7:0] got_b, exp_b;
    chk({tag, "_sclk_rises"}, sclk_rises, 8 * exp_q.size());
    i = 0;
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      got_b = 8'h00;
      if (8 * i + 8 <= bits_q.size()) begin
        for (int b = 0; b < 8; b++) got_b = {got_b[6:0], bits_q[8 * i + b]};
        chk($sformatf("%s_byte%0d", tag, i), got_b, exp_b);
      end else begin
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'hdead, exp_b);
      end
      i++;
    end
  endtask

  // driver: one write frame, bytes already in prod_q
  task automatic run_write(input string tag, input logic [7:0] addr, input logic [LW-1:0] len,
                           input int n_take, input int exp_lat);
    int t0;
    @(posedge clk);
    #1;
    mon_clear();
    exp_q.delete();
    exp_q.push_back(addr);
    for (int i = 0; i < n_take; i++) exp_q.push_back(prod_q[i]);
    chk({tag, "_ready_idle"}, req_ready, 1);
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, "_ready_low"}, req_ready, 0);
    wait_done(1, 400);
    chk({tag, "_done_lat"}, done_cyc - t0, exp_lat);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_iclk"}, iclk_pulses, IRST_PULSES);
    chk({tag, "_data_ready"}, dr_cnt, n_take);
    check_stream(tag);
    prod_reset();
  endtask

  int t0, d1, r1, i1, dr1;

  initial begin
    rstn      = 1'b1;
    req_valid = 1'b0;
    rst_req   = 1'b0;
    req_addr  = 8'h00;
    req_len   = '0;
    #2 rstn = 1'b0;
    #10;
    chk("rst_sclk", sclk, 0);
    chk("rst_serial_in", serial_in, 0);
    chk("rst_iclk", iclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_ready", data_ready, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);

    // three-byte burst, no stalls
    prod_q = '{8'h10, 8'h02, 8'h01};
    run_write("burst3", 8'h01, 3'(3), 3, 17 * 3 + 17 + IRST_CYC);

    // same burst, producer idle for 5 FETCH cycles before byte 2
    prod_q    = '{8'h10, 8'h02, 8'h01};
    stall_at  = 1;
    stall_len = 16 + 5;
    run_write("stall", 8'h01, 3'(3), 3, 17 * 3 + 17 + IRST_CYC + 5);

    // address-only frame
    prod_q = '{8'h77};
    run_write("addr_only", 8'hA5, 3'(0), 0, 17 + IRST_CYC);

    // length clamp: 7 requested, 7 offered, MAX_BYTES taken
    prod_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_write("clamp", 8'h80, 3'(7), MAX_BYTES, 17 * MAX_BYTES + 17 + IRST_CYC);

    // rst_req wins over a simultaneous write; the write is taken afterwards
    @(posedge clk);
    #1;
    mon_clear();
    prod_q    = '{8'h99};
    req_addr  = 8'h3C;
    req_len   = 3'(1);
    req_valid = 1'b1;
    rst_req   = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    wait_done(1, 100);
    d1  = done_cyc;
    r1  = sclk_rises;
    i1  = iclk_pulses;
    dr1 = dr_cnt;
    chk("irst_done_lat", d1 - t0, 17);
    chk("irst_sclk", r1, 0);
    chk("irst_iclk", i1, 8);
    chk("irst_data_ready", dr1, 0);
    chk("irst_ready_after", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done(2, 200);
    chk("irst_write_lat", done_cyc - t0, 18 + 17 + 17 + IRST_CYC);
    chk("irst_write_iclk", iclk_pulses, 8 + IRST_PULSES);
    chk("irst_write_dr", dr_cnt, 1);
    exp_q.delete();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h99);
    check_stream("irst_write");
    prod_reset();

    // async reset during the 3rd data bit (sclk high, serial_in high)
    repeat (2) @(posedge clk);
    #1;
    mon_clear();
    prod_q    = '{8'hE0, 8'h00, 8'h00};
    req_addr  = 8'h01;
    req_len   = 3'(3);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    chk("mid_sclk_pre", sclk, 1);
    chk("mid_serial_in_pre", serial_in, 1);
    chk("mid_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_sclk", sclk, 0);
    chk("mid_serial_in", serial_in, 0);
    chk("mid_iclk", iclk, 0);
    chk("mid_busy", busy, 0);
    prod_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_busy_after", busy, 0);

    // recovery frame after the reset
    prod_q = '{8'h00};
    run_write("recover", 8'h5A, 3'(0), 0, 17 + IRST_CYC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
